// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings and helpers for the universal shift register.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_INV  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    // Shift and rotate modes are the ones that advance the frame counter.
    function automatic logic is_shift(input logic [2:0] mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR) ||
               (mode == MODE_ROL) || (mode == MODE_ROR);
    endfunction

endpackage

// File: rtl/univ_shift_reg_frame_counter.sv
// Frame counter: counts shift ops, wraps at WIDTH-1 and pulses done on the wrap.
// Latency: cnt and done are registered, valid one cycle after the sampling edge.
// Backpressure: none; inc is simply ignored when low (done drops to 0).
//
// Ports: clk, rst (sync), clr (sync restart of the frame), inc (one shift op),
//        cnt (ops in current frame), done (one-cycle pulse on frame completion).
module frame_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (inc) begin
            // Explicit wrap so non-power-of-two widths never pass WIDTH-1.
            if (cnt == LAST) begin
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal N-bit register: hold/shift/rotate/load/invert with serial I/O on both ends.
// Latency: q updates one cycle after the sampling edge; nq/sout_* are combinational from q.
// Backpressure: none; en=0 freezes q and cnt for as long as it is low.
//
// Ports: clk, rst (sync, highest priority), pre (sync preset), en (clock enable),
//        mode (op select), sin_l (enters MSB on shift right), sin_r (enters LSB on
//        shift left), d (parallel load), q/nq (contents and complement),
//        sout_l/sout_r (MSB/LSB), cnt (shift ops in frame), done (frame pulse).
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRE_VAL = {WIDTH{1'b1}},
    localparam int              CW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pre,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    logic [WIDTH-1:0] q_nxt;
    logic             cnt_clr;
    logic             cnt_inc;

    always_comb begin
        q_nxt = q;
        unique case (mode)
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], sin_r};
            MODE_SHR:  q_nxt = {sin_l, q[WIDTH-1:1]};
            MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
            MODE_LOAD: q_nxt = d;
            MODE_INV:  q_nxt = ~q;
            default:   q_nxt = q;   // hold and reserved
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (pre) begin
            q <= PRE_VAL;   // preset does not need en
        end else if (en) begin
            q <= q_nxt;
        end
    end

    // Preset and parallel load both start a new frame; rst is handled separately
    // inside the counter so its priority is explicit there too.
    assign cnt_clr = pre || (en && (mode == MODE_LOAD));
    assign cnt_inc = en && is_shift(mode);

    frame_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_frame_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .done (done)
    );

    assign nq     = ~q;
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised N-bit register built from the single-bit D flip-flop with reset and preset. It adds hold, shift, rotate, parallel-load and invert modes, plus serial in/out on both ends. A shift counter produces a one-cycle frame-done pulse after WIDTH shift or rotate operations. It serves as the general storage and serialiser primitive for the datapath.

Parameters:
WIDTH, 8, register width in bits; legal range 2..32.
RST_VAL, {WIDTH{1'b0}}, value loaded by rst.
PRE_VAL, {WIDTH{1'b1}}, value loaded by pre.
CW, $clog2(WIDTH), width of the shift counter; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous active-high reset.
pre  input  1  synchronous active-high preset.
en  input  1  clock enable; 0 = hold everything.
mode  input  3  operation select, see Behaviour.
sin_l  input  1  serial input entering at the MSB (shift right).
sin_r  input  1  serial input entering at the LSB (shift left).
d  input  WIDTH  parallel load data.
q  output  WIDTH  register contents.
nq  output  WIDTH  ~q, combinational.
sout_l  output  1  q[WIDTH-1], combinational.
sout_r  output  1  q[0], combinational.
cnt  output  CW  number of shift/rotate operations in the current frame.
done  output  1  registered one-cycle pulse marking frame completion.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). No asynchronous paths.
- Reset state: q=RST_VAL, cnt=0, done=0. nq, sout_l and sout_r follow q.
- Priority each edge: rst > pre > (en==0) > mode.
- pre: q<=PRE_VAL, cnt<=0, done<=0.
- en==0: q and cnt hold; done<=0.
- Mode encoding with en==1:
  - 000 hold.
  - 001 shift left: q<={q[W-2:0],sin_r}.
  - 010 shift right: q<={sin_l,q[W-1:1]}.
  - 011 rotate left: q<={q[W-2:0],q[W-1]}.
  - 100 rotate right: q<={q[0],q[W-1:1]}.
  - 101 parallel load: q<=d.
  - 110 invert: q<=~q.
  - 111 reserved, behaves as hold.
- Latency: q reflects the operation one cycle after the edge that samples it.
- Counter:
  - Modes 001-100 are shift ops. On each shift op, cnt increments.
  - If cnt==WIDTH-1 on a shift op: cnt wraps to 0 and done<=1 for exactly one cycle.
  - done<=0 on every other edge.
  - Parallel load (101) clears cnt to 0 and starts a new frame.
  - Hold and invert leave cnt unchanged.
  - Non-power-of-two WIDTH: cnt never exceeds WIDTH-1.
- Mid-frame rst or pre: cnt clears, done is suppressed, and the frame restarts.
- Simultaneous rst and pre: rst wins, q=RST_VAL.
- Simultaneous pre and en=0: pre wins. Preset does not require en.
- mode may change every cycle; no settling cycles are required.

Decomposition:
- Shared package shift_pkg holds:
  - the mode localparams MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_LOAD, MODE_INV;
  - a function is_shift(mode).
- One natural sub-module: frame_counter (CW-bit counter with wrap-at-WIDTH-1, sync clear, done pulse), instantiated once.
- The q register and next-state mux stay in the top module.

Test Plan (WIDTH=8):
1. rst=1 one cycle with d=8'hFF and mode=101 -> q=8'h00, nq=8'hFF, cnt=0, done=0. Then pre=1 with rst=1 -> q=8'h00. Then pre=1 alone -> q=8'hFF.
2. Load 8'hA5, then 8 cycles of mode 011 -> q visits 4B,96,2D,5A,B4,69,D2,A5. cnt counts 1..7 then wraps to 0. done is high only in the cycle after the 8th rotate.
3. Load 8'h81, shift left with sin_r=0 for 2 cycles -> q=8'h04. sout_l is 1 before the first shift and 0 after. Then shift right with sin_l=1 -> q=8'h82.
4. Load 8'h3C, drop en for 3 cycles while mode=001 -> q stays 3C and cnt stays 0. Raise en with mode=110 -> q=8'hC3, cnt unchanged.
5. 5 rotates (cnt=5), then parallel load 8'h11 -> cnt=0. 8 further shifts are needed before done pulses.
6. 6 shifts, then rst -> cnt=0 and no done pulse. Also check mode=111 holds q.
